// File: rtl/mac_sequencer.sv
// Host-side sequencer for the serial 8x8 MAC core: serialises operand pairs, pulses do_next,
// waits for finish, then deserialises the 20-bit result onto a valid/ready port.
module mac_sequencer #(
  parameter int unsigned N_PAIRS     = 9,
  parameter int unsigned HOLD        = 2,
  parameter int unsigned SETTLE      = 20,
  parameter int unsigned GAP         = 100,
  parameter int unsigned FIN_TIMEOUT = 65535
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        job_start,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [7:0]  op_a,
  input  logic [7:0]  op_b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [19:0] res_data,
  output logic        busy,
  output logic        err,
  output logic        mac_start,
  output logic        mac_shiftA,
  output logic        mac_shiftB,
  output logic        mac_shift,
  output logic        mac_do_next,
  input  logic        mac_finish,
  input  logic        mac_shiftout
);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_WAIT0, S_GET_OP, S_SHIFT_IN, S_SETTLE, S_NEXT, S_GAP,
    S_WAIT_FIN, S_PRE_OUT, S_SHIFT_OUT, S_RESULT
  } state_t;

  localparam logic [31:0] HOLD_LAST   = 32'(HOLD - 1);
  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE - 1);
  localparam logic [31:0] GAP_LAST    = 32'(GAP - 1);
  localparam logic [31:0] FIN_LAST    = 32'(FIN_TIMEOUT - 1);
  localparam logic [7:0]  NP          = 8'(N_PAIRS);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [4:0]  bit_q, bit_d;
  logic [1:0]  phase_q, phase_d;
  logic [7:0]  pair_q, pair_d;
  logic [7:0]  opa_q, opa_d, opb_q, opb_d;
  logic [19:0] res_q, res_d;
  logic        err_q, err_d;
  logic        op_ready_q, op_ready_d;
  logic        res_valid_q, res_valid_d;
  logic        busy_q, busy_d;
  logic        mac_start_q, mac_start_d;
  logic        mac_shift_a_q, mac_shift_a_d;
  logic        mac_shift_b_q, mac_shift_b_d;
  logic        mac_shift_q, mac_shift_d;
  logic        mac_do_next_q, mac_do_next_d;
  logic        hold_end;
  logic [4:0]  last_bit;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 32'd1;
    bit_d    = bit_q;
    phase_d  = phase_q;
    pair_d   = pair_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    res_d    = res_q;
    err_d    = err_q;
    hold_end = (cnt_q == HOLD_LAST);
    last_bit = (state_q == S_SHIFT_IN) ? 5'd7 : 5'd19;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (job_start) begin
          state_d = S_START;
          pair_d  = '0;
          err_d   = 1'b0;
          res_d   = '0;
        end
      end
      S_START: begin
        state_d = S_WAIT0;
        cnt_d   = '0;
      end
      S_WAIT0: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_GET_OP;
          cnt_d   = '0;
        end
      end
      S_GET_OP: begin
        cnt_d = '0;
        if (op_valid && op_ready_q) begin
          opa_d   = op_a;
          opb_d   = op_b;
          state_d = S_SHIFT_IN;
          bit_d   = '0;
          phase_d = '0;
        end
      end
      S_SHIFT_IN, S_SHIFT_OUT: begin
        // Result bit is taken at the end of setup, before its shift pulse.
        if (state_q == S_SHIFT_OUT && phase_q == 2'd0 && hold_end)
          res_d = res_q | (20'(mac_shiftout) << bit_q);
        if (hold_end) begin
          cnt_d = '0;
          if (phase_q == 2'd2) begin
            phase_d = '0;
            if (bit_q == last_bit) begin
              bit_d   = '0;
              state_d = (state_q == S_SHIFT_IN) ? S_SETTLE : S_RESULT;
            end else begin
              bit_d = bit_q + 5'd1;
            end
          end else begin
            phase_d = phase_q + 2'd1;
          end
        end
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_NEXT;
          cnt_d   = '0;
        end
      end
      S_NEXT: begin
        if (cnt_q == 32'd2) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          pair_d  = pair_q + 8'd1;
          state_d = (pair_d == NP) ? S_WAIT_FIN : S_GET_OP;
        end
      end
      S_WAIT_FIN: begin
        if (mac_finish) begin
          state_d = S_PRE_OUT;
          cnt_d   = '0;
        end else if (cnt_q == FIN_LAST) begin
          err_d   = 1'b1;
          res_d   = '0;
          state_d = S_RESULT;
          cnt_d   = '0;
        end
      end
      S_PRE_OUT: begin
        if (cnt_q == 32'd1) begin
          state_d = S_SHIFT_OUT;
          cnt_d   = '0;
          bit_d   = '0;
          phase_d = '0;
        end
      end
      S_RESULT: begin
        cnt_d = '0;
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so the pins themselves are flops.
    busy_d        = (state_d != S_IDLE);
    op_ready_d    = (state_d == S_GET_OP);
    res_valid_d   = (state_d == S_RESULT);
    mac_start_d   = (state_d == S_START);
    mac_do_next_d = (state_d == S_NEXT);
    mac_shift_d   = (state_d == S_SHIFT_IN || state_d == S_SHIFT_OUT) && (phase_d == 2'd1);
    mac_shift_a_d = (state_d == S_SHIFT_IN) && opa_d[3'd7 - bit_d[2:0]];
    mac_shift_b_d = (state_d == S_SHIFT_IN) && opb_d[3'd7 - bit_d[2:0]];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      bit_q         <= '0;
      phase_q       <= '0;
      pair_q        <= '0;
      opa_q         <= '0;
      opb_q         <= '0;
      res_q         <= '0;
      err_q         <= 1'b0;
      op_ready_q    <= 1'b0;
      res_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      mac_start_q   <= 1'b0;
      mac_shift_a_q <= 1'b0;
      mac_shift_b_q <= 1'b0;
      mac_shift_q   <= 1'b0;
      mac_do_next_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_q         <= bit_d;
      phase_q       <= phase_d;
      pair_q        <= pair_d;
      opa_q         <= opa_d;
      opb_q         <= opb_d;
      res_q         <= res_d;
      err_q         <= err_d;
      op_ready_q    <= op_ready_d;
      res_valid_q   <= res_valid_d;
      busy_q        <= busy_d;
      mac_start_q   <= mac_start_d;
      mac_shift_a_q <= mac_shift_a_d;
      mac_shift_b_q <= mac_shift_b_d;
      mac_shift_q   <= mac_shift_d;
      mac_do_next_q <= mac_do_next_d;
    end
  end

  assign op_ready    = op_ready_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_q;
  assign busy        = busy_q;
  assign err         = err_q;
  assign mac_start   = mac_start_q;
  assign mac_shiftA  = mac_shift_a_q;
  assign mac_shiftB  = mac_shift_b_q;
  assign mac_shift   = mac_shift_q;
  assign mac_do_next = mac_do_next_q;

endmodule

// File: doc/mac_sequencer.md
# mac_sequencer

Host-side controller for the serial 8x8 multiply-accumulate core (`my_chip`). It accepts parallel operand pairs over a valid/ready port and serialises them onto the core's shiftA/shiftB/shift pins. It pulses do_next per pair, waits for finish, then deserialises the 20-bit accumulated result onto a valid/ready result port. It sits between a parallel host bus and the MAC pins, so software never bit-bangs the core.

## Interface
- `N_PAIRS`, 9: operand pairs per job (1..255)
- `HOLD`, 2: cycles per shift phase (setup, shift-high, shift-low), ≥1
- `SETTLE`, 20: idle cycles after each shift-in, before do_next
- `GAP`, 100: idle cycles after do_next, and after mac_start
- `FIN_TIMEOUT`, 65535: max cycles waiting for mac_finish
- `clock` in 1: single clock; all logic on its rising edge
- `reset` in 1: asynchronous, active-high; clears all state
- `job_start` in 1: one-cycle request to begin a job; honoured only in IDLE
- `op_valid` in 1 / `op_ready` out 1: operand handshake
- `op_a` in 8 / `op_b` in 8: operand pair, captured on handshake
- `res_valid` out 1 / `res_ready` in 1: result handshake
- `res_data` out 20: accumulated result
- `busy` out 1: high in every state except IDLE
- `err` out 1: sticky timeout flag, cleared by next accepted job_start or reset
- `mac_start`, `mac_shiftA`, `mac_shiftB`, `mac_shift`, `mac_do_next` out 1 each: core pins
- `mac_finish`, `mac_shiftout` in 1 each: core pins, synchronous to `clock`

## Operation
- States: IDLE → START → WAIT0 → GET_OP → SHIFT_IN → SETTLE → NEXT → GAP → (GET_OP | WAIT_FIN) → PRE_OUT → SHIFT_OUT → RESULT → IDLE.
- IDLE: on job_start, clear pair counter and err, go to START.
- START: mac_start=1 for exactly 1 cycle. WAIT0: GAP cycles.
- GET_OP: op_ready=1. On op_valid&&op_ready, latch op_a/op_b and go to SHIFT_IN. op_ready is 0 in all other states.
- SHIFT_IN: 8 bits, MSB first. Each bit has three phases of HOLD cycles:
  - setup: shiftA/shiftB = bit, shift=0
  - high: shift=1
  - low: shift=0
  - shiftA/shiftB hold the current bit through all three phases.
- SETTLE: SETTLE cycles. NEXT: mac_do_next=1 for 3 cycles.
- GAP: GAP cycles, then increment the pair counter. If count==N_PAIRS go to WAIT_FIN, else GET_OP.
- WAIT_FIN: wait for mac_finish=1. If FIN_TIMEOUT cycles elapse first, set err, force res_data=0, go to RESULT.
- PRE_OUT: 2 cycles.
- SHIFT_OUT: 20 bits, LSB first, same 3-phase pattern. mac_shiftout is sampled on the last cycle of the setup phase into res_data[i], before that bit's shift pulse.
- RESULT: res_valid=1 and res_data stable until res_valid&&res_ready, then IDLE. If res_ready is already high on entry, the handshake completes in that first cycle.
- Widths: the pair counter is 8 bits and never wraps, because N_PAIRS ≤ 255. res_data is exactly the core's 20 bits with no carry extension.

## Timing
- Reset values: every output 0 (op_ready, res_valid, res_data, busy, err, all mac_* pins). State is IDLE.
- Reset mid-operation: outputs return to 0 asynchronously and the state goes to IDLE. The core is not otherwise notified; the host must assert job_start again.
- job_start while busy: ignored, with no queueing.
- Per-pair latency from the op handshake to the next op_ready: 24·HOLD + SETTLE + 3 + GAP cycles. This is 171 cycles at defaults.
- Shift-out: 60·HOLD cycles (120 at defaults), then res_valid on the next cycle.
- busy rises the cycle after the accepted job_start and falls the cycle after the result handshake.
- mac_start/mac_do_next pulse widths are exact. No mac_* output glitches, because all are registered.
- op_valid held low in GET_OP: the controller waits indefinitely, and mac_* stay 0.

## Test plan
- Default job with pairs (i+2, i+3), i=0..8, against the real core: res_data=438, err=0, busy low after the result handshake.
- Waveform check, pair (0xA5, 0x3C): shiftA sequence 1,0,1,0,0,1,0,1 and shiftB sequence 0,0,1,1,1,1,0,0. Each bit has shift high for exactly HOLD cycles, and there is exactly one 3-cycle do_next per pair.
- Backpressure: op_valid delayed 50 cycles per pair and res_ready held low 30 cycles. Result is unchanged (438), op_ready stays high while waiting, and res_data is stable while res_valid=1.
- Timeout: core model never asserts finish, FIN_TIMEOUT=500. Required: err=1, res_valid=1 with res_data=0. A later job_start clears err.
- Reset during SHIFT_IN of pair 4: all outputs 0 immediately. A fresh job after reset completes correctly with 438.
- job_start pulsed during GAP and during RESULT: ignored. Exactly one mac_start is observed per job.
